// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// FSM states, mux selects, ALU op classes and RV32I opcodes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_PC4  = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_ALU    = 2'd2;

    localparam logic       PC_ALU    = 1'b0;
    localparam logic       PC_ALUOUT = 1'b1;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    // Opcodes that take the S_EX path; anything else retires as a NOP.
    function automatic logic needs_ex(input logic [6:0] op);
        return (op == OP_ARITH)  || (op == OP_ARITH_IMM) ||
               (op == OP_LOAD)   || (op == OP_STORE)     ||
               (op == OP_BRANCH) || (op == OP_JAL)       ||
               (op == OP_JALR);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Dwell counter for fixed-latency memory accesses.
// Ports: clk, reset, enable (count), clear (dominant) -> last.
module mem_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic last
);

    localparam int W = $clog2(MEM_LAT) + 1;

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (clear)
            wait_cnt <= '0;
        else if (enable)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign last = (wait_cnt == W'(MEM_LAT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences PC/IR/MDR/ALUOut/regfile/memory
// strobes per state. Optional MC_PERF_CNT_EN adds cycle/retired counters.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  part_of_inst,
    input  logic        bcond,
    input  logic        ecall_halt,
    output logic        pc_write,
    output logic        pc_source,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mdr_write,
    output logic        aluout_write,
    output logic        reg_write,
    output logic [1:0]  reg_wd_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        is_ecall,
    output logic        is_halted,
`ifdef MC_PERF_CNT_EN
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count,
`endif
    output logic [2:0]  state
);

    state_t state_q;
    state_t state_d;
    logic   in_access;
    logic   last;

    assign in_access = (state_q == S_IF) || (state_q == S_MEM);

    mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .enable (in_access),
        .clear  (last || !in_access),
        .last   (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IF;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        pc_source    = PC_ALU;
        ir_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mdr_write    = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        reg_wd_sel   = WD_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_REG;
        alu_op       = ALU_ADD;
        is_ecall     = 1'b0;
        is_halted    = 1'b0;

        unique case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = last;
                if (last)
                    state_d = S_ID;
            end
            S_ID: begin
                alu_src_b    = SRCB_IMM;
                aluout_write = 1'b1;
                if (part_of_inst == OP_ECALL) begin
                    is_ecall = 1'b1;
                    state_d  = ecall_halt ? S_HALT : S_PC4;
                end else if (needs_ex(part_of_inst)) begin
                    state_d = S_EX;
                end else begin
                    state_d = S_PC4;
                end
            end
            S_EX: begin
                state_d = S_IF;
                case (part_of_inst)
                    OP_ARITH: begin
                        alu_src_a    = SRCA_REG;
                        alu_op       = ALU_FUNCT;
                        aluout_write = 1'b1;
                        state_d      = S_WB;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_a    = SRCA_REG;
                        alu_src_b    = SRCB_IMM;
                        alu_op       = ALU_FUNCT;
                        aluout_write = 1'b1;
                        state_d      = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a    = SRCA_REG;
                        alu_src_b    = SRCB_IMM;
                        aluout_write = 1'b1;
                        state_d      = S_MEM;
                    end
                    OP_JALR: begin
                        alu_src_a    = SRCA_REG;
                        alu_src_b    = SRCB_IMM;
                        aluout_write = 1'b1;
                        state_d      = S_WB;
                    end
                    OP_JAL: begin
                        // ALU forms the link PC+4; target PC+imm sits in ALUOut.
                        alu_src_b  = SRCB_FOUR;
                        reg_write  = 1'b1;
                        reg_wd_sel = WD_ALU;
                        pc_write   = 1'b1;
                        pc_source  = PC_ALUOUT;
                    end
                    OP_BRANCH: begin
                        alu_src_a = SRCA_REG;
                        alu_op    = ALU_BRANCH;
                        if (bcond) begin
                            pc_write  = 1'b1;
                            pc_source = PC_ALUOUT;
                        end else begin
                            state_d = S_PC4;
                        end
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (part_of_inst == OP_STORE) begin
                    mem_write = 1'b1;
                    if (last) begin
                        pc_write  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                        state_d   = S_IF;
                    end
                end else begin
                    mem_read  = 1'b1;
                    mdr_write = last;
                    if (last)
                        state_d = S_WB;
                end
            end
            S_WB: begin
                alu_src_b = SRCB_FOUR;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_IF;
                case (part_of_inst)
                    OP_LOAD: reg_wd_sel = WD_MDR;
                    OP_JALR: begin
                        reg_wd_sel = WD_ALU;
                        pc_source  = PC_ALUOUT;
                    end
                    default: reg_wd_sel = WD_ALUOUT;
                endcase
            end
            S_PC4: begin
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
            default: state_d = S_IF;
        endcase

        // Reset is asynchronous, so strobes must drop in the same cycle.
        if (reset) begin
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mdr_write    = 1'b0;
            aluout_write = 1'b0;
            reg_write    = 1'b0;
            is_ecall     = 1'b0;
            is_halted    = 1'b0;
        end
    end

    assign state = state_q;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (state_q != S_HALT)
                cycle_count <= cycle_count + 32'd1;
            if ((state_d != state_q) &&
                ((state_d == S_IF) || (state_d == S_HALT)))
                retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with MEM_LAT=1 and MEM_LAT=3.
// Each step checks the state code and the full strobe vector.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst1;
    logic       rst3;
    logic [6:0] opc;
    logic       bcond;
    logic       ehalt;
    logic [17:0] v1, v3;
    logic [2:0]  st1, st3;
    int checks = 0;
    int failures = 0;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc1, ret1, cyc3, ret3;
`endif

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_LAT(1)) u1 (
        .clk(clk), .reset(rst1), .part_of_inst(opc),
        .bcond(bcond), .ecall_halt(ehalt),
        .pc_write(v1[17]), .pc_source(v1[16]), .ir_write(v1[15]),
        .i_or_d(v1[14]), .mem_read(v1[13]), .mem_write(v1[12]),
        .mdr_write(v1[11]), .aluout_write(v1[10]), .reg_write(v1[9]),
        .reg_wd_sel(v1[8:7]), .alu_src_a(v1[6]), .alu_src_b(v1[5:4]),
        .alu_op(v1[3:2]), .is_ecall(v1[1]), .is_halted(v1[0]),
`ifdef MC_PERF_CNT_EN
        .cycle_count(cyc1), .retired_count(ret1),
`endif
        .state(st1)
    );

    multicycle_control_unit #(.MEM_LAT(3)) u3 (
        .clk(clk), .reset(rst3), .part_of_inst(opc),
        .bcond(bcond), .ecall_halt(ehalt),
        .pc_write(v3[17]), .pc_source(v3[16]), .ir_write(v3[15]),
        .i_or_d(v3[14]), .mem_read(v3[13]), .mem_write(v3[12]),
        .mdr_write(v3[11]), .aluout_write(v3[10]), .reg_write(v3[9]),
        .reg_wd_sel(v3[8:7]), .alu_src_a(v3[6]), .alu_src_b(v3[5:4]),
        .alu_op(v3[3:2]), .is_ecall(v3[1]), .is_halted(v3[0]),
`ifdef MC_PERF_CNT_EN
        .cycle_count(cyc3), .retired_count(ret3),
`endif
        .state(st3)
    );

    function automatic logic [17:0] mk(
        input logic pw, ps, irw, iod, mr, mw, mdr, ao, rw,
        input logic [1:0] wd, input logic a,
        input logic [1:0] b, op, input logic ec, ht);
        return {pw, ps, irw, iod, mr, mw, mdr, ao, rw, wd, a, b, op, ec, ht};
    endfunction

    localparam logic [17:0] V_IF   = mk(0,0,1,0,1,0,0,0,0,0,0,0,0,0,0);
    localparam logic [17:0] V_IFW  = mk(0,0,0,0,1,0,0,0,0,0,0,0,0,0,0);
    localparam logic [17:0] V_ID   = mk(0,0,0,0,0,0,0,1,0,0,0,2,0,0,0);
    localparam logic [17:0] V_IDE  = mk(0,0,0,0,0,0,0,1,0,0,0,2,0,1,0);
    localparam logic [17:0] V_EXR  = mk(0,0,0,0,0,0,0,1,0,0,1,0,2,0,0);
    localparam logic [17:0] V_EXI  = mk(0,0,0,0,0,0,0,1,0,0,1,2,2,0,0);
    localparam logic [17:0] V_EXA  = mk(0,0,0,0,0,0,0,1,0,0,1,2,0,0,0);
    localparam logic [17:0] V_MLD  = mk(0,0,0,1,1,0,1,0,0,0,0,0,0,0,0);
    localparam logic [17:0] V_MLW  = mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    localparam logic [17:0] V_MST  = mk(1,0,0,1,0,1,0,0,0,0,0,1,0,0,0);
    localparam logic [17:0] V_WBR  = mk(1,0,0,0,0,0,0,0,1,0,0,1,0,0,0);
    localparam logic [17:0] V_WBL  = mk(1,0,0,0,0,0,0,0,1,1,0,1,0,0,0);
    localparam logic [17:0] V_JMP  = mk(1,1,0,0,0,0,0,0,1,2,0,1,0,0,0);
    localparam logic [17:0] V_BT   = mk(1,1,0,0,0,0,0,0,0,0,1,0,1,0,0);
    localparam logic [17:0] V_BN   = mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0,0);
    localparam logic [17:0] V_PC4  = mk(1,0,0,0,0,0,0,0,0,0,0,1,0,0,0);
    localparam logic [17:0] V_HLT  = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    localparam logic [17:0] V_ZERO = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check current cycle of the selected DUT, then advance one clock.
    task automatic step(input string tag, input bit sel3,
                        input logic [2:0] es, input logic [17:0] ev);
        chk({tag, ".state"}, 32'(sel3 ? st3 : st1), 32'(es));
        chk({tag, ".strb"},  32'(sel3 ? v3 : v1),   32'(ev));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1  = 1'b1;
        rst3  = 1'b1;
        opc   = 7'b0110011;
        bcond = 1'b0;
        ehalt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst1.state", 32'(st1), 32'd0);
        chk("rst1.strb",  32'(v1),  32'(V_ZERO));
        chk("rst3.state", 32'(st3), 32'd0);
        chk("rst3.strb",  32'(v3),  32'(V_ZERO));
        @(negedge clk);
        rst1 = 1'b0;
        #1;

        // ADD
        step("add.if", 0, 0, V_IF);
        step("add.id", 0, 1, V_ID);
        step("add.ex", 0, 2, V_EXR);
        step("add.wb", 0, 4, V_WBR);
        // ADDI
        opc = 7'b0010011;
        step("addi.if", 0, 0, V_IF);
        step("addi.id", 0, 1, V_ID);
        step("addi.ex", 0, 2, V_EXI);
        step("addi.wb", 0, 4, V_WBR);
        // LW
        opc = 7'b0000011;
        step("lw.if",  0, 0, V_IF);
        step("lw.id",  0, 1, V_ID);
        step("lw.ex",  0, 2, V_EXA);
        step("lw.mem", 0, 3, V_MLD);
        step("lw.wb",  0, 4, V_WBL);
        // SW
        opc = 7'b0100011;
        step("sw.if",  0, 0, V_IF);
        step("sw.id",  0, 1, V_ID);
        step("sw.ex",  0, 2, V_EXA);
        step("sw.mem", 0, 3, V_MST);
        // BEQ taken
        opc = 7'b1100011;
        bcond = 1'b1;
        step("bt.if", 0, 0, V_IF);
        step("bt.id", 0, 1, V_ID);
        step("bt.ex", 0, 2, V_BT);
        // BEQ not taken
        bcond = 1'b0;
        step("bn.if",  0, 0, V_IF);
        step("bn.id",  0, 1, V_ID);
        step("bn.ex",  0, 2, V_BN);
        step("bn.pc4", 0, 5, V_PC4);
        // JAL
        opc = 7'b1101111;
        step("jal.if", 0, 0, V_IF);
        step("jal.id", 0, 1, V_ID);
        step("jal.ex", 0, 2, V_JMP);
        // JALR
        opc = 7'b1100111;
        step("jalr.if", 0, 0, V_IF);
        step("jalr.id", 0, 1, V_ID);
        step("jalr.ex", 0, 2, V_EXA);
        step("jalr.wb", 0, 4, V_JMP);
        // Unknown opcode retires as NOP
        opc = 7'b0000000;
        step("nop.if",  0, 0, V_IF);
        step("nop.id",  0, 1, V_ID);
        step("nop.pc4", 0, 5, V_PC4);
        // ECALL without halt
        opc = 7'b1110011;
        step("ec0.if",  0, 0, V_IF);
        step("ec0.id",  0, 1, V_IDE);
        step("ec0.pc4", 0, 5, V_PC4);
        // ECALL with halt
        ehalt = 1'b1;
        step("ec1.if", 0, 0, V_IF);
        step("ec1.id", 0, 1, V_IDE);
        for (int i = 0; i < 20; i++)
            step("halt", 0, 6, V_HLT);
        ehalt = 1'b0;
`ifdef MC_PERF_CNT_EN
        chk("perf.cycles",  cyc1, 32'd39);
        chk("perf.retired", ret1, 32'd11);
`endif

        // MEM_LAT=3 load
        opc = 7'b0000011;
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        step("l3.if0",  1, 0, V_IFW);
        step("l3.if1",  1, 0, V_IFW);
        step("l3.if2",  1, 0, V_IF);
        step("l3.id",   1, 1, V_ID);
        step("l3.ex",   1, 2, V_EXA);
        step("l3.mem0", 1, 3, V_MLW);
        step("l3.mem1", 1, 3, V_MLW);
        step("l3.mem2", 1, 3, V_MLD);
        step("l3.wb",   1, 4, V_WBL);
        // Second load, reset during 2nd MEM cycle
        step("r3.if0",  1, 0, V_IFW);
        step("r3.if1",  1, 0, V_IFW);
        step("r3.if2",  1, 0, V_IF);
        step("r3.id",   1, 1, V_ID);
        step("r3.ex",   1, 2, V_EXA);
        step("r3.mem0", 1, 3, V_MLW);
        chk("r3.mem1.state", 32'(st3), 32'd3);
        chk("r3.mem1.strb",  32'(v3),  32'(V_MLW));
        rst3 = 1'b1;
        #1;
        chk("r3.async.state", 32'(st3), 32'd0);
        chk("r3.async.strb",  32'(v3),  32'(V_ZERO));
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        step("r3.ref0", 1, 0, V_IFW);
        step("r3.ref1", 1, 0, V_IFW);
        step("r3.ref2", 1, 0, V_IF);
        step("r3.id2",  1, 1, V_ID);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style FSM (Mealy only for branch pc_write) that sequences the shared-ALU, shared-memory multicycle RV32I datapath. Decodes the IR opcode and drives per-state strobes for PC, IR, MDR, ALUOut, register file, memory and ALU operand muxes. Replaces the single-cycle opcode decoder in the multicycle CPU top. Tolerates fixed multi-cycle memory latency.

Parameters:
MEM_LAT, 1, cycles each memory access occupies (>=1); IF and MEM dwell exactly MEM_LAT cycles.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state to S_IF
part_of_inst  input  7  opcode field of IR (codes from opcodes.v)
bcond  input  1  branch comparison result from ALU, valid in S_EX of BRANCH
ecall_halt  input  1  datapath flag: x17==10, valid in S_ID
pc_write  output  1  PC register load
pc_source  output  1  0=ALU result, 1=ALUOut
ir_write  output  1  IR load
i_or_d  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mdr_write  output  1  MDR load
aluout_write  output  1  ALUOut load
reg_write  output  1  register file write
reg_wd_sel  output  2  write data: 0=ALUOut, 1=MDR, 2=ALU result
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  0=B, 1=constant 4, 2=immediate
alu_op  output  2  0=ADD, 1=BRANCH compare, 2=FUNCT decode
is_ecall  output  1  high in S_ID when opcode is ECALL
is_halted  output  1  high in S_HALT
state  output  3  current state, debug

Behaviour:
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_PC4=5, S_HALT=6; codes 7 → S_IF next cycle.
- Reset: state=S_IF, wait_cnt=0; all strobes 0 while reset high; first fetch cycle follows deassertion.
- Strobes default 0; only listed ones asserted.
- wait_cnt (width clog2(MEM_LAT)+1): increments in S_IF/S_MEM, clears on leaving; "last" = (wait_cnt==MEM_LAT-1).
- S_IF: mem_read, i_or_d=0; ir_write only on last; stay until last, then S_ID.
- S_ID: alu_src_a=0, alu_src_b=2, alu_op=ADD, aluout_write (PC+imm). ECALL: is_ecall; ecall_halt → S_HALT else S_PC4. Unknown opcode → S_PC4 (NOP). Others → S_EX.
- S_EX by opcode:
  ARITHMETIC: a=1,b=0,op=FUNCT, aluout_write → S_WB.
  ARITHMETIC_IMM: a=1,b=2,op=FUNCT, aluout_write → S_WB.
  LOAD/STORE: a=1,b=2,op=ADD, aluout_write → S_MEM.
  JALR: a=1,b=2,op=ADD, aluout_write → S_WB.
  JAL: a=0,b=1,op=ADD, reg_write, reg_wd_sel=2, pc_write, pc_source=1 → S_IF.
  BRANCH: a=1,b=0,op=BRANCH; bcond=1: pc_write, pc_source=1 → S_IF; bcond=0 → S_PC4.
- S_MEM: i_or_d=1. LOAD: mem_read, mdr_write on last → S_WB after last. STORE: mem_write all cycles; on last also pc_write, a=0,b=1,op=ADD,pc_source=0 → S_IF.
- S_WB: a=0,b=1,op=ADD, reg_write, pc_write. R/I-type: wd_sel=0, pc_source=0. LOAD: wd_sel=1, pc_source=0. JALR: wd_sel=2, pc_source=1 (datapath clears bit 0) → S_IF.
- S_PC4: a=0,b=1,op=ADD, pc_write, pc_source=0 → S_IF.
- S_HALT: absorbing until reset; no strobes.
- Opcode sampled combinationally from IR; IR stable from S_ID onward.
- Reset mid-access drops mem_read/mem_write same cycle (asynchronous).

Optional Feature:
MC_PERF_CNT_EN: adds outputs cycle_count[31:0] (increments every non-reset cycle outside S_HALT) and retired_count[31:0] (increments on each transition into S_IF or S_HALT from another state); both reset to 0, wrap at 2^32. Without macro: ports and counters absent; all else identical.

Decomposition:
- Shared package mc_ctrl_pkg: state encodings, alu_op, alu_src_b, reg_wd_sel, pc_source constants; opcode codes stay in opcodes.v.
- Sub-module mem_wait_counter (MEM_LAT, enable, clear → last); instanced once, shared by S_IF/S_MEM.

Test Plan:
- MEM_LAT=1, ADD → states IF,ID,EX,WB (4 cycles); reg_write+pc_write only in WB, wd_sel=0.
- MEM_LAT=1, LW then SW → 5 cycles with mdr_write in MEM and wd_sel=1 in WB; SW 4 cycles, mem_write+pc_write in MEM, reg_write never.
- BEQ bcond=1 → 3 cycles, pc_write/pc_source=1 in EX; bcond=0 → 4 cycles via S_PC4, pc_source=0.
- JAL → 3 cycles, EX reg_write wd_sel=2 pc_source=1; JALR → 4 cycles, WB wd_sel=2 pc_source=1.
- MEM_LAT=3, LW → 9 cycles; ir_write only in 3rd IF cycle, mdr_write only in 3rd MEM cycle; reset in 2nd MEM cycle → state=0 and mem_read=0 immediately, next fetch wait_cnt=0.
- ECALL ecall_halt=0 → IF,ID,PC4 (3 cycles); ecall_halt=1 → S_HALT, is_halted=1 held 20 cycles; with MC_PERF_CNT_EN retired_count increments once per instruction.
